// File: rtl/reg_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_spi_arbiter
//  Description : Two-requester, round-robin SPI master. It serialises
//                register-write frames MSB-first onto the reg SPI slave port
//                (csb / sclk / mosi) and leaves a deselect gap between frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_spi_arbiter #(
    parameter int SCLK_HALF = 2,   // clk cycles per sclk half-period, 1..15
    parameter int MAX_BITS  = 32   // request data width
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_r0_valid,
    output logic                o_r0_ready,
    input  logic [MAX_BITS-1:0] i_r0_data,
    input  logic [5:0]          i_r0_len,
    input  logic                i_r1_valid,
    output logic                o_r1_ready,
    input  logic [MAX_BITS-1:0] i_r1_data,
    input  logic [5:0]          i_r1_len,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_busy,
    output logic                o_grant
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [3:0] C_PHASE_LAST = 4'(SCLK_HALF - 1);
    localparam logic [5:0] C_MAX_LEN    = 6'(MAX_BITS);

    state_t              state_q, state_d;
    logic [3:0]          phase_q, phase_d;
    logic [5:0]          count_q, count_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                csb_q, csb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;

    logic                w_sel;
    logic                w_accept;
    logic                w_phase_done;
    logic [MAX_BITS-1:0] w_acc_data;
    logic [5:0]          w_acc_len;
    logic [5:0]          w_eff_len;

    // Round-robin selection and combinational ready handshake (IDLE only)
    always_comb begin
        if (i_r0_valid && i_r1_valid) begin
            w_sel = ~last_grant_q;
        end else begin
            w_sel = i_r1_valid;
        end
        w_accept     = (state_q == ST_IDLE) && (i_r0_valid || i_r1_valid);
        o_r0_ready   = w_accept && !w_sel;
        o_r1_ready   = w_accept && w_sel;
        w_acc_data   = w_sel ? i_r1_data : i_r0_data;
        w_acc_len    = w_sel ? i_r1_len  : i_r0_len;
        // Lengths beyond the data width saturate to a full-width frame
        w_eff_len    = (w_acc_len > C_MAX_LEN) ? C_MAX_LEN : w_acc_len;
        w_phase_done = (phase_q == C_PHASE_LAST);
    end

    // Frame sequencer: next state, shifter, bit counter and arbitration history
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    last_grant_d = w_sel;
                    grant_d      = w_sel;
                    // A zero-length frame is consumed but produces no bus activity
                    if (w_eff_len != 6'd0) begin
                        shift_d = w_acc_data << (C_MAX_LEN - w_eff_len);
                        count_d = w_eff_len;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (w_phase_done) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (w_phase_done) begin
                    count_d = count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        shift_d = shift_q << 1;
                        state_d = ST_LO;
                    end
                end
            end
            ST_HOLD: begin
                if (w_phase_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_phase_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Phase counter restarts on every state change and idles at zero
        if ((state_d == state_q) && (state_q != ST_IDLE)) begin
            phase_d = phase_q + 4'd1;
        end else begin
            phase_d = '0;
        end
    end

    // Bus outputs decoded from the next state so the flops present them glitch-free
    always_comb begin
        csb_d  = !((state_d == ST_LO) || (state_d == ST_HI) || (state_d == ST_HOLD));
        sclk_d = (state_d == ST_HI);
        mosi_d = ((state_d == ST_LO) || (state_d == ST_HI)) ? shift_d[MAX_BITS-1] : 1'b0;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset (aborts any frame)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            count_q      <= '0;
            shift_q      <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            csb_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            csb_q        <= csb_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
        end
    end

    assign o_csb   = csb_q;
    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;
    assign o_busy  = busy_q;
    assign o_grant = grant_q;

endmodule
`default_nettype wire
